dct_8x8_pass_sequencer: RTL and testbench
=========================================

Name: dct_8x8_pass_sequencer

Overview:
- Sequences the 8-point 1-D DCT engine over a full 8x8 block: 8 row passes, then 8 column passes.
- Row results go to a transpose scratchpad; column results go to the output buffer.
- Sits between the block loader (upstream valid/ready) and the entropy/quant stage (downstream valid/ready).
- Drives engine start, source select and read/write base/stride; watchdogs the engine.

Parameters:
- PASS_COUNT, 8, passes per phase (rows, then columns); pass index width 3.
- TIMEOUT_CYCLES, 64, maximum cycles in a WAIT state before fault.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- block_valid  in  1  input buffer holds a complete 8x8 block.
- block_ready  out  1  sequencer idle, accepts a block.
- eng_start  out  1  one-cycle pulse, starts one 1-D DCT pass.
- eng_done  in  1  one-cycle pulse from the engine, pass complete.
- eng_src_sel  out  1  0 = input buffer, 1 = transpose scratchpad.
- eng_rd_base  out  6  first sample address of the pass.
- eng_rd_stride  out  4  read address step (always 1).
- eng_wr_base  out  6  first result address of the pass.
- eng_wr_stride  out  4  write address step (always 8, transposing).
- eng_wr_dst  out  1  0 = scratchpad, 1 = output buffer.
- out_valid  out  1  coefficient block complete in the output buffer.
- out_ready  in  1  downstream has taken the block.
- error  out  1  sticky engine-timeout fault.

Behaviour:
- States: IDLE, ROW_START, ROW_WAIT, COL_START, COL_WAIT, DONE, FAULT.
- Registers:
  - pass (3 bit)
  - tmo (7 bit, counts up to TIMEOUT_CYCLES)
- Reset, synchronous (takes effect at the next edge from any state, including mid-pass):
  - state = IDLE, pass = 0, tmo = 0.
  - eng_start = 0, out_valid = 0, error = 0.
  - eng_src_sel = 0, eng_wr_dst = 0.
  - eng_rd_base = 0, eng_wr_base = 0, eng_rd_stride = 1, eng_wr_stride = 8.
  - A late eng_done from an aborted pass is ignored.
- Output decode:
  - block_ready = (state == IDLE).
  - eng_start = 1 only in ROW_START and COL_START.
  - out_valid = 1 only in DONE.
  - error = 1 only in FAULT.
- IDLE: block_valid & block_ready -> ROW_START, pass = 0.
- ROW_START (1 cycle):
  - eng_src_sel = 0, eng_wr_dst = 0.
  - eng_rd_base = 8*pass, eng_wr_base = pass.
  - Next state ROW_WAIT, tmo = 0.
- ROW_WAIT:
  - On eng_done: if pass == PASS_COUNT-1, go to COL_START with pass = 0; else go to ROW_START with pass + 1.
  - Otherwise tmo increments; reaching TIMEOUT_CYCLES -> FAULT.
- COL_START / COL_WAIT: identical to the row states, except:
  - eng_src_sel = 1, eng_wr_dst = 1.
  - Last done -> DONE.
- DONE: hold out_valid until out_ready; on handshake -> IDLE. block_ready = 1 on the next cycle.
- FAULT:
  - Absorbing; only reset exits.
  - block_ready = 0, eng_start = 0.
- Address/select outputs are registered, updated on entry to each START state, and held stable through the matching WAIT.
- eng_done is sampled only in WAIT states; it is ignored in START, IDLE and DONE.
- Latency:
  - Engine done k >= 1 cycles after the start cycle gives k+1 cycles per pass.
  - Accept at edge T0 gives out_valid at T0 + 16(k+1) + 1.
- block_valid during a pass has no effect: no second acceptance until IDLE.

Test Plan:
- Single block, engine model with k=5: accept at T0 -> 16 eng_start pulses spaced 6 cycles apart; out_valid rises at T0+97. The (rd_base, wr_base) sequence is:
  - Rows: (0,0), (8,1), …, (56,7) with src_sel=0, wr_dst=0.
  - Columns: the same pairs with src_sel=1, wr_dst=1.
- Downstream backpressure: out_ready held 0 for 20 cycles -> out_valid stays 1 and block_ready stays 0. out_ready=1 -> next cycle block_ready=1.
- Back-to-back: block_valid held 1 and out_ready tied 1 -> second block accepted exactly 1 cycle after the DONE handshake; no extra start pulses.
- Spurious done: eng_done pulsed in IDLE and during ROW_START -> pass does not advance; exactly 16 starts per block.
- Timeout: engine never returns done on row pass 3 -> error=1 exactly 64 cycles after that pass's WAIT entry; no further eng_start. reset -> IDLE, error=0.
- Reset mid-operation: reset asserted during COL_WAIT pass 5 -> next cycle all outputs at reset values. A subsequent block runs a full 16-pass sequence starting at rd_base 0.

Source files
------------

// File: rtl/dct_8x8_pass_sequencer.sv
// Pass sequencer for the 8-point 1-D DCT engine over one 8x8 block.
// Runs 8 row passes into the transpose scratchpad, then 8 column passes
// into the output buffer, with a watchdog on each engine pass.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a block from the loader (block_ready high)
// ROW_START | one-cycle engine start for row pass 'pass'
// ROW_WAIT  | waiting for eng_done of the current row pass
// COL_START | one-cycle engine start for column pass 'pass'
// COL_WAIT  | waiting for eng_done of the current column pass
// DONE      | coefficient block ready, waiting for out_ready
// FAULT     | engine timeout, held until reset
module dct_8x8_pass_sequencer #(
    parameter int PASS_COUNT     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       block_valid,
    output logic       block_ready,
    output logic       eng_start,
    input  logic       eng_done,
    output logic       eng_src_sel,
    output logic [5:0] eng_rd_base,
    output logic [3:0] eng_rd_stride,
    output logic [5:0] eng_wr_base,
    output logic [3:0] eng_wr_stride,
    output logic       eng_wr_dst,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ROW_START = 3'd1,
        ROW_WAIT  = 3'd2,
        COL_START = 3'd3,
        COL_WAIT  = 3'd4,
        DONE      = 3'd5,
        FAULT     = 3'd6
    } state_t;

    localparam logic [2:0] PASS_LAST = 3'(PASS_COUNT - 1);
    localparam logic [6:0] TMO_LIMIT = 7'(TIMEOUT_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] pass;
    logic [2:0] pass_nxt;
    logic [6:0] tmo;
    logic [6:0] tmo_nxt;

    // Next-state, pass index and watchdog counter decode
    always_comb begin
        state_nxt = state;
        pass_nxt  = pass;
        tmo_nxt   = tmo;
        case (state)
            IDLE: begin
                if (block_valid) begin
                    state_nxt = ROW_START;
                    pass_nxt  = 3'd0;
                end
            end
            ROW_START: begin
                state_nxt = ROW_WAIT;
                tmo_nxt   = 7'd0;
            end
            ROW_WAIT: begin
                if (eng_done) begin
                    if (pass == PASS_LAST) begin
                        state_nxt = COL_START;
                        pass_nxt  = 3'd0;
                    end else begin
                        state_nxt = ROW_START;
                        pass_nxt  = pass + 3'd1;
                    end
                end else begin
                    tmo_nxt = tmo + 7'd1;
                    if (tmo_nxt == TMO_LIMIT) begin
                        state_nxt = FAULT;
                    end
                end
            end
            COL_START: begin
                state_nxt = COL_WAIT;
                tmo_nxt   = 7'd0;
            end
            COL_WAIT: begin
                if (eng_done) begin
                    if (pass == PASS_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = COL_START;
                        pass_nxt  = pass + 3'd1;
                    end
                end else begin
                    tmo_nxt = tmo + 7'd1;
                    if (tmo_nxt == TMO_LIMIT) begin
                        state_nxt = FAULT;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; engine addressing is loaded only when entering a START
    // state so it stays stable for the whole pass
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pass        <= 3'd0;
            tmo         <= 7'd0;
            eng_src_sel <= 1'b0;
            eng_wr_dst  <= 1'b0;
            eng_rd_base <= 6'd0;
            eng_wr_base <= 6'd0;
        end else begin
            state <= state_nxt;
            pass  <= pass_nxt;
            tmo   <= tmo_nxt;
            if ((state_nxt == ROW_START) || (state_nxt == COL_START)) begin
                eng_src_sel <= (state_nxt == COL_START);
                eng_wr_dst  <= (state_nxt == COL_START);
                eng_rd_base <= {pass_nxt, 3'b000};
                eng_wr_base <= {3'b000, pass_nxt};
            end
        end
    end

    assign block_ready   = (state == IDLE);
    assign eng_start     = (state == ROW_START) || (state == COL_START);
    assign out_valid     = (state == DONE);
    assign error         = (state == FAULT);
    assign eng_rd_stride = 4'd1;
    assign eng_wr_stride = 4'd8;

endmodule

// File: tb/tb_dct_8x8_pass_sequencer.sv
// Scoreboard bench for dct_8x8_pass_sequencer with a fixed-latency engine model.
module tb_dct_8x8_pass_sequencer;

    localparam int K = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       block_valid;
    logic       block_ready;
    logic       eng_start;
    logic       eng_done;
    logic       eng_src_sel;
    logic [5:0] eng_rd_base;
    logic [3:0] eng_rd_stride;
    logic [5:0] eng_wr_base;
    logic [3:0] eng_wr_stride;
    logic       eng_wr_dst;
    logic       out_valid;
    logic       out_ready;
    logic       error;

    dct_8x8_pass_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .block_valid   (block_valid),
        .block_ready   (block_ready),
        .eng_start     (eng_start),
        .eng_done      (eng_done),
        .eng_src_sel   (eng_src_sel),
        .eng_rd_base   (eng_rd_base),
        .eng_rd_stride (eng_rd_stride),
        .eng_wr_base   (eng_wr_base),
        .eng_wr_stride (eng_wr_stride),
        .eng_wr_dst    (eng_wr_dst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .error         (error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [13:0] tup;
    } start_exp_t;

    start_exp_t sq[$];
    int         ovq[$];
    int         erq[$];
    int         passed = 0;
    int         total = 0;

    int eng_cnt  = -1;
    int n_starts = 0;
    int hang_idx = -1;
    int spur1    = -1;
    int spur2    = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [13:0] mk(input int p, input bit col);
        return {6'(8 * p), 6'(p), col, col};
    endfunction

    // Expected start records for passes 0..n-1 of a block accepted in cycle c
    task automatic push_starts(input int c, input int n);
        start_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc = c + 1 + (K + 1) * i;
            e.tup = mk(i % 8, i >= 8);
            sq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_block_ready"}, block_ready, 1);
        chk({tag, "_eng_start"}, eng_start, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_src_dst"}, {eng_src_sel, eng_wr_dst}, 0);
        chk({tag, "_rd_base"}, eng_rd_base, 0);
        chk({tag, "_wr_base"}, eng_wr_base, 0);
        chk({tag, "_strides"}, {eng_rd_stride, eng_wr_stride}, 8'h18);
    endtask

    // Engine model: done pulse K cycles after the start cycle, optional hang, spurious pulses
    initial begin
        eng_done = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            eng_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_cnt  = -1;
                end
            end
            if (cyc == spur1 || cyc == spur2) eng_done = 1'b1;
            @(negedge clock);
            if (eng_start) begin
                if (n_starts != hang_idx) eng_cnt = K;
                n_starts++;
            end
        end
    end

    // Monitor: pops expected start records and out_valid/error rise times
    initial begin
        logic        prev_ov;
        logic        prev_er;
        logic        hold_pending;
        logic [13:0] cur;
        start_exp_t  e;
        prev_ov      = 1'b0;
        prev_er      = 1'b0;
        hold_pending = 1'b0;
        cur          = '0;
        forever begin
            @(negedge clock);
            if (hold_pending) begin
                chk("addr_hold", {eng_rd_base, eng_wr_base, eng_src_sel, eng_wr_dst}, cur);
                hold_pending = 1'b0;
            end
            if (eng_start) begin
                chk("start_expected", sq.size() > 0, 1);
                if (sq.size() > 0) begin
                    e = sq.pop_front();
                    chk("start_cycle", cyc, e.cyc);
                    chk("start_addr", {eng_rd_base, eng_wr_base, eng_src_sel, eng_wr_dst}, e.tup);
                    chk("start_strides", {eng_rd_stride, eng_wr_stride}, 8'h18);
                    cur          = e.tup;
                    hold_pending = 1'b1;
                end
            end
            if (out_valid && !prev_ov) begin
                chk("out_valid_expected", ovq.size() > 0, 1);
                if (ovq.size() > 0) chk("out_valid_cycle", cyc, ovq.pop_front());
            end
            if (error && !prev_er) begin
                chk("error_expected", erq.size() > 0, 1);
                if (erq.size() > 0) chk("error_cycle", cyc, erq.pop_front());
            end
            prev_ov = out_valid;
            prev_er = error;
        end
    end

    // Global time limit
    initial begin
        #40000;
        $display("FAIL time_limit: got cycle %0d expected finish before it", cyc);
        $fatal(1, "time limit");
    end

    // Directed stimulus
    initial begin
        int c;
        reset       = 1'b1;
        block_valid = 1'b0;
        out_ready   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk_reset_outputs("por");
        tick();

        // Single block, spurious done in IDLE and in ROW_START, backpressure
        spur1 = cyc + 2;
        wait_until(cyc + 4);
        c = cyc;
        spur2 = c + 13;
        block_valid = 1'b1;
        push_starts(c, 16);
        ovq.push_back(c + 97);
        tick();
        block_valid = 1'b0;
        wait_until(c + 30);
        block_valid = 1'b1;
        chk("busy_block_ready", block_ready, 0);
        wait_until(c + 60);
        block_valid = 1'b0;
        wait_until(c + 97);
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_block_ready", block_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_block_ready", block_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);
        tick();

        // Back-to-back blocks with out_ready tied high
        c = cyc;
        out_ready   = 1'b1;
        block_valid = 1'b1;
        push_starts(c, 16);
        ovq.push_back(c + 97);
        push_starts(c + 98, 16);
        ovq.push_back(c + 98 + 97);
        wait_until(c + 98);
        chk("b2b_accept_ready", block_ready, 1);
        tick();
        block_valid = 1'b0;
        chk("b2b_busy_ready", block_ready, 0);
        wait_until(c + 196);
        chk("b2b_final_ready", block_ready, 1);
        out_ready = 1'b0;
        tick();

        // Engine hang on row pass 3
        hang_idx = n_starts + 3;
        c = cyc;
        block_valid = 1'b1;
        push_starts(c, 4);
        erq.push_back(c + 84);
        tick();
        wait_until(c + 83);
        chk("pre_tmo_error", error, 0);
        tick();
        chk("tmo_error", error, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("fault_error", error, 1);
            chk("fault_block_ready", block_ready, 0);
        end
        block_valid = 1'b0;
        reset       = 1'b1;
        tick();
        reset    = 1'b0;
        hang_idx = -1;
        chk_reset_outputs("fault_rst");
        tick();

        // Reset during column pass 5, then a clean block
        c = cyc;
        block_valid = 1'b1;
        push_starts(c, 14);
        tick();
        block_valid = 1'b0;
        wait_until(c + 81);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs("mid_rst");
        chk("mid_rst_starts_left", sq.size(), 0);
        wait_until(c + 90);
        chk("late_done_block_ready", block_ready, 1);
        c = cyc;
        block_valid = 1'b1;
        push_starts(c, 16);
        ovq.push_back(c + 97);
        tick();
        block_valid = 1'b0;
        out_ready   = 1'b1;
        wait_until(c + 99);
        chk("final_block_ready", block_ready, 1);
        repeat (3) tick();

        chk("starts_left", sq.size(), 0);
        chk("out_valid_left", ovq.size(), 0);
        chk("error_left", erq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
